reg_file_mp: RTL and testbench

Parametrised multi-port general-purpose register file for the pipelined core, successor to the two-read/one-write file used by decode. Provides READ_PORTS registered read ports, one writeback port, one dedicated link (jal) port, and a per-register busy scoreboard so decode can detect pending producers. Sits between the decode stage (reads, issue) and the write stage (writeback).

---
 rtl/reg_file_mp.sv | 132 +++++++++++++
 tb/tb_reg_file_mp.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp -- multi-port general-purpose register file with busy scoreboard.
//
// Purpose:
//   READ_PORTS registered read ports, one writeback port, one dedicated
//   link (jal) port that always targets register REG_NUM-1, and a
//   per-register busy scoreboard that tracks pending producers for decode.
//   Register 0 is hard-wired to zero and is never busy.
//
// Optional feature (compile-time macro):
//   REG_FILE_BYPASS_EN  defined   -> a read of a register being written in
//                                    the same cycle returns the new value
//                                    (the link value wins on a collision).
//                       undefined -> reads return the pre-write array value.
//   In both builds rd_busy reports the next-state busy bit.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   rd_addr    in   READ_PORTS*AW read addresses, port p at [p*AW +: AW]
//   rd_data    out  READ_PORTS*DATA_W registered read data, same packing
//   rd_busy    out  READ_PORTS registered busy flags of addressed registers
//   wb_en      in   writeback enable
//   wb_addr    in   writeback destination
//   wb_data    in   writeback value
//   link_en    in   link write enable (target REG_NUM-1)
//   link_data  in   link return address
//   issue_en   in   destination issue_addr becomes pending
//   issue_addr in   destination being marked pending

module reg_file_mp #(
    parameter int DATA_W     = 32,
    parameter int REG_NUM    = 32,
    parameter int READ_PORTS = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [READ_PORTS*$clog2(REG_NUM)-1:0] rd_addr,
    output logic [READ_PORTS*DATA_W-1:0]   rd_data,
    output logic [READ_PORTS-1:0]          rd_busy,
    input  logic                           wb_en,
    input  logic [$clog2(REG_NUM)-1:0]     wb_addr,
    input  logic [DATA_W-1:0]              wb_data,
    input  logic                           link_en,
    input  logic [DATA_W-1:0]              link_data,
    input  logic                           issue_en,
    input  logic [$clog2(REG_NUM)-1:0]     issue_addr
);

    localparam int AW = $clog2(REG_NUM);
    localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};
    localparam logic [AW-1:0] LINK_ADDR = {AW{1'b1}};

    logic [DATA_W-1:0]            regs_r [REG_NUM];
    logic [REG_NUM-1:0]           busy_r;
    logic [REG_NUM-1:0]           busy_next_s;
    logic [READ_PORTS*DATA_W-1:0] rd_data_next_s;
    logic [READ_PORTS-1:0]        rd_busy_next_s;

    // Next-state scoreboard: a set on the same register as a clear wins,
    // because the issuing instruction is the newer producer.
    always_comb begin
        busy_next_s = {REG_NUM{1'b0}};
        for (int r = 1; r < REG_NUM; r++) begin
            busy_next_s[r] = (issue_en && (issue_addr == AW'(r)))
                           || (busy_r[r]
                               && !(wb_en && (wb_addr == AW'(r)))
                               && !(link_en && (r == REG_NUM - 1)));
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= {REG_NUM{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Register array; the link write is issued last so it overrides a
    // writeback to the same register. Register 0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_NUM; r++) begin
                regs_r[r] <= {DATA_W{1'b0}};
            end
        end else begin
            if (wb_en && (wb_addr != ZERO_ADDR)) begin
                regs_r[wb_addr] <= wb_data;
            end
            if (link_en) begin
                regs_r[LINK_ADDR] <= link_data;
            end
        end
    end

    // Per-port read selection: zero register, optional same-cycle bypass,
    // otherwise the stored value.
    always_comb begin
        logic [AW-1:0] addr_v;
        addr_v         = ZERO_ADDR;
        rd_data_next_s = {(READ_PORTS*DATA_W){1'b0}};
        rd_busy_next_s = {READ_PORTS{1'b0}};
        for (int p = 0; p < READ_PORTS; p++) begin
            addr_v = rd_addr[p*AW +: AW];
            if (addr_v == ZERO_ADDR) begin
                rd_data_next_s[p*DATA_W +: DATA_W] = {DATA_W{1'b0}};
`ifdef REG_FILE_BYPASS_EN
            end else if (link_en && (addr_v == LINK_ADDR)) begin
                rd_data_next_s[p*DATA_W +: DATA_W] = link_data;
            end else if (wb_en && (addr_v == wb_addr)) begin
                rd_data_next_s[p*DATA_W +: DATA_W] = wb_data;
`endif
            end else begin
                rd_data_next_s[p*DATA_W +: DATA_W] = regs_r[addr_v];
            end
            rd_busy_next_s[p] = busy_next_s[addr_v];
        end
    end

    // Registered read outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= {(READ_PORTS*DATA_W){1'b0}};
            rd_busy <= {READ_PORTS{1'b0}};
        end else begin
            rd_data <= rd_data_next_s;
            rd_busy <= rd_busy_next_s;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp -- scoreboard bench for reg_file_mp.
// Two instances: the default configuration (32x32, 2 ports) and a
// 16x64 four-port configuration. Expected read results are queued when a
// read is driven and compared one clock later when the DUT presents them.
// Honours REG_FILE_BYPASS_EN for the same-cycle read expectations.

module tb_reg_file_mp;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int NP  = 2;
    localparam int PAW = 4;
    localparam int PDW = 64;
    localparam int PNP = 4;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    // default instance
    logic [NP*AW-1:0]     rd_addr;
    logic [NP*DW-1:0]     rd_data;
    logic [NP-1:0]        rd_busy;
    logic                 wb_en;
    logic [AW-1:0]        wb_addr;
    logic [DW-1:0]        wb_data;
    logic                 link_en;
    logic [DW-1:0]        link_data;
    logic                 issue_en;
    logic [AW-1:0]        issue_addr;
    // parametrised instance
    logic [PNP*PAW-1:0]   p_rd_addr;
    logic [PNP*PDW-1:0]   p_rd_data;
    logic [PNP-1:0]       p_rd_busy;
    logic                 p_wb_en;
    logic [PAW-1:0]       p_wb_addr;
    logic [PDW-1:0]       p_wb_data;
    logic                 p_link_en;
    logic [PDW-1:0]       p_link_data;
    logic                 p_issue_en;
    logic [PAW-1:0]       p_issue_addr;

    reg_file_mp dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .link_en(link_en), .link_data(link_data),
        .issue_en(issue_en), .issue_addr(issue_addr)
    );

    reg_file_mp #(.DATA_W(PDW), .REG_NUM(16), .READ_PORTS(PNP)) dut_p (
        .clk(clk), .rst(rst),
        .rd_addr(p_rd_addr), .rd_data(p_rd_data), .rd_busy(p_rd_busy),
        .wb_en(p_wb_en), .wb_addr(p_wb_addr), .wb_data(p_wb_data),
        .link_en(p_link_en), .link_data(p_link_data),
        .issue_en(p_issue_en), .issue_addr(p_issue_addr)
    );

    typedef struct {
        string       tag;
        int          inst;
        int          port;
        logic [63:0] data;
        logic        busy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic chk_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rd_addr = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        link_en = 1'b0; link_data = '0; issue_en = 1'b0; issue_addr = '0;
        p_rd_addr = '0; p_wb_en = 1'b0; p_wb_addr = '0; p_wb_data = '0;
        p_link_en = 1'b0; p_link_data = '0; p_issue_en = 1'b0; p_issue_addr = '0;
    endtask

    task automatic rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic prd(input int p, input int a);
        p_rd_addr[p*PAW +: PAW] = PAW'(a);
    endtask

    task automatic wb(input int a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = AW'(a); wb_data = d;
    endtask

    task automatic issue(input int a);
        issue_en = 1'b1; issue_addr = AW'(a);
    endtask

    task automatic expect_rd(input string tag, input int inst, input int port,
                             input logic [63:0] d, input logic b);
        exp_t e;
        e.tag = tag; e.inst = inst; e.port = port; e.data = d; e.busy = b;
        sb.push_back(e);
    endtask

    // Clock once, compare everything queued for this edge, then idle inputs.
    task automatic step();
        exp_t        e;
        logic [63:0] obs_d;
        logic        obs_b;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.inst == 0) begin
                obs_d = {32'h0, rd_data[e.port*DW +: DW]};
                obs_b = rd_busy[e.port];
            end else begin
                obs_d = p_rd_data[e.port*PDW +: PDW];
                obs_b = p_rd_busy[e.port];
            end
            chk_value({e.tag, "_data"}, obs_d, e.data);
            chk_value({e.tag, "_busy"}, {63'h0, obs_b}, {63'h0, e.busy});
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        // reset state of both instances
        for (int p = 0; p < NP; p++)  expect_rd("rst_init", 0, p, 64'h0, 1'b0);
        for (int p = 0; p < PNP; p++) expect_rd("p_rst_init", 1, p, 64'h0, 1'b0);
        step();
        rst = 1'b0;

        // preload r5, then read it while issuing r5
        wb(5, 32'h0000_1234);
        step();
        rd(0, 5); issue(5);
        expect_rd("pre_r5", 0, 0, 64'h1234, 1'b1);
        step();

        // reset overrides concurrent writes / issue / link
        rst = 1'b1;
        rd(0, 5); rd(1, 6); wb(6, 32'h0000_BEEF); issue(7);
        link_en = 1'b1; link_data = 32'h0000_0777;
        p_link_en = 1'b1; p_link_data = 64'hFFFF;
        expect_rd("rst_ovr0", 0, 0, 64'h0, 1'b0);
        expect_rd("rst_ovr1", 0, 1, 64'h0, 1'b0);
        step();
        rst = 1'b0;
        rd(0, 5); rd(1, 6); prd(0, 15);
        expect_rd("post_rst_r5", 0, 0, 64'h0, 1'b0);
        expect_rd("post_rst_r6", 0, 1, 64'h0, 1'b0);
        expect_rd("p_post_rst_r15", 1, 0, 64'h0, 1'b0);
        step();

        // basic write/read, plus link write on the 16x64 instance
        wb(7, 32'hDEAD_BEEF);
        p_link_en = 1'b1; p_link_data = 64'h0123_4567_89AB_CDEF;
        step();
        rd(0, 7); rd(1, 0);
        for (int p = 0; p < PNP; p++) begin
            prd(p, 15);
            expect_rd("p_r15", 1, p, 64'h0123_4567_89AB_CDEF, 1'b0);
        end
        expect_rd("rd_r7", 0, 0, 64'hDEAD_BEEF, 1'b0);
        expect_rd("rd_r0", 0, 1, 64'h0, 1'b0);
        step();

        // same-cycle bypass
        wb(3, 32'h0000_0001);
        step();
        wb(3, 32'hA5A5_A5A5); rd(0, 3);
        expect_rd("byp_r3", 0, 0, BYP ? 64'hA5A5_A5A5 : 64'h1, 1'b0);
        step();
        rd(0, 3);
        expect_rd("after_r3", 0, 0, 64'hA5A5_A5A5, 1'b0);
        step();

        // write collision: link wins over writeback on r31
        wb(31, 32'h0000_0100); link_en = 1'b1; link_data = 32'h0000_0400; rd(0, 31);
        expect_rd("coll_same", 0, 0, BYP ? 64'h400 : 64'h0, 1'b0);
        step();
        wb(0, 32'h0000_FFFF); rd(0, 31); rd(1, 0);
        expect_rd("coll_r31", 0, 0, 64'h400, 1'b0);
        expect_rd("wr_r0_same", 0, 1, 64'h0, 1'b0);
        step();
        rd(1, 0);
        expect_rd("wr_r0", 0, 1, 64'h0, 1'b0);
        step();

        // scoreboard
        issue(9); rd(0, 9);
        expect_rd("sb_issue", 0, 0, 64'h0, 1'b1);
        step();
        rd(0, 9);
        expect_rd("sb_hold", 0, 0, 64'h0, 1'b1);
        step();
        wb(9, 32'h0000_0099); issue(9); rd(0, 9);
        expect_rd("sb_set_clr", 0, 0, BYP ? 64'h99 : 64'h0, 1'b1);
        step();
        wb(9, 32'h0000_0055); rd(0, 9);
        expect_rd("sb_clr", 0, 0, BYP ? 64'h55 : 64'h99, 1'b0);
        step();
        issue(0); rd(0, 0); rd(1, 9);
        expect_rd("sb_issue_r0", 0, 0, 64'h0, 1'b0);
        expect_rd("sb_r9_final", 0, 1, 64'h55, 1'b0);
        step();

        // link clears busy of the link register
        issue(31); rd(0, 31);
        expect_rd("sb_issue_r31", 0, 0, 64'h400, 1'b1);
        step();
        link_en = 1'b1; link_data = 32'h0000_0800; rd(0, 31); rd(1, 31);
        expect_rd("sb_link_clr0", 0, 0, BYP ? 64'h800 : 64'h400, 1'b0);
        expect_rd("sb_link_clr1", 0, 1, BYP ? 64'h800 : 64'h400, 1'b0);
        step();
        rd(0, 31);
        expect_rd("link_r31", 0, 0, 64'h800, 1'b0);
        step();

        if (sb.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
